// File: rtl/laser_frame_sequencer_if.sv
// Bus between the laser frame sequencer and whatever configures and consumes it.
// Carries the run control pulses, the latched-on-start configuration and the timing outputs.
interface laser_frame_sequencer_if;
  // start/stop are single-cycle request pulses with no ready: start is taken only in IDLE,
  // stop only in RUN; a pulse offered at any other time is dropped, never queued.
  logic        start;
  logic        stop;
  logic [31:0] laser_freq;
  logic [15:0] pulses_bg;
  logic [15:0] pulses_a;
  logic [15:0] pulses_b;
  logic [15:0] num_seq;
  logic [31:0] laser_cnt_out;
  logic [1:0]  frame_type;
  logic        laser_trig;
  logic        frame_start;
  logic        busy;
  logic        done;
  logic        state_dbg;

  modport master (
    output start, stop, laser_freq, pulses_bg, pulses_a, pulses_b, num_seq,
    input  laser_cnt_out, frame_type, laser_trig, frame_start, busy, done, state_dbg
  );

  modport slave (
    input  start, stop, laser_freq, pulses_bg, pulses_a, pulses_b, num_seq,
    output laser_cnt_out, frame_type, laser_trig, frame_start, busy, done, state_dbg
  );
endinterface

// File: rtl/laser_frame_sequencer.sv
// Laser period counter, trigger pulse and BG -> A -> B frame stepping for the gate generator.
// All outputs are registered; state is visible on bus.state_dbg.
module laser_frame_sequencer #(
    parameter int TRIG_WIDTH = 16
) (
    input logic               clk,
    input logic               rst_n,
    laser_frame_sequencer_if.slave bus
);

    localparam logic [0:0]  ST_IDLE  = 1'b0;
    localparam logic [0:0]  ST_RUN   = 1'b1;
    localparam logic [1:0]  FT_BG    = 2'd0;
    localparam logic [1:0]  FT_A     = 2'd1;
    localparam logic [1:0]  FT_B     = 2'd2;
    localparam logic [31:0] TRIG_LIM = 32'(TRIG_WIDTH);

    // en bit 0 = BG, bit 1 = A, bit 2 = B; at least one bit is set whenever these are used.
    function automatic logic [1:0] first_frame(input logic [2:0] en);
        if (en[0])      return FT_BG;
        else if (en[1]) return FT_A;
        else            return FT_B;
    endfunction

    function automatic logic [1:0] next_frame(input logic [1:0] ft, input logic [2:0] en);
        case (ft)
            FT_BG:   return en[1] ? FT_A  : (en[2] ? FT_B  : FT_BG);
            FT_A:    return en[2] ? FT_B  : (en[0] ? FT_BG : FT_A);
            default: return en[0] ? FT_BG : (en[1] ? FT_A  : FT_B);
        endcase
    endfunction

    logic [0:0]  state, state_n;
    logic [31:0] freq_l, freq_n;
    logic [15:0] pbg_l, pbg_n, pa_l, pa_n, pb_l, pb_n, nseq_l, nseq_n;
    logic [31:0] cnt, cnt_n;
    logic [15:0] frame_cnt, frame_cnt_n, seq_cnt, seq_cnt_n;
    logic [1:0]  ft, ft_n;
    logic        stop_pend, stop_pend_n;
    logic        end_run;

    logic [2:0]  en_in, en_l;
    logic        start_ok, eop;
    logic [15:0] cur_pulses, frame_cnt_inc, seq_inc;
    logic [1:0]  adv_ft;
    logic        adv_wrap;
    logic [31:0] trig_lim;

    assign en_in = {bus.pulses_b != 16'd0, bus.pulses_a != 16'd0, bus.pulses_bg != 16'd0};
    assign en_l  = {pb_l != 16'd0, pa_l != 16'd0, pbg_l != 16'd0};

    assign start_ok      = (state == ST_IDLE) && bus.start && (en_in != 3'b000);
    assign eop           = (state == ST_RUN) && (cnt == freq_l);
    assign frame_cnt_inc = frame_cnt + 16'd1;
    assign seq_inc       = seq_cnt + 16'd1;
    assign adv_ft        = next_frame(ft, en_l);
    // Landing on an equal or earlier frame means we went past the last enabled one.
    assign adv_wrap      = (adv_ft <= ft);

    always_comb begin
        case (ft)
            FT_A:    cur_pulses = pa_l;
            FT_B:    cur_pulses = pb_l;
            default: cur_pulses = pbg_l;
        endcase
    end

    always_comb begin
        state_n     = state;
        freq_n      = freq_l;
        pbg_n       = pbg_l;
        pa_n        = pa_l;
        pb_n        = pb_l;
        nseq_n      = nseq_l;
        cnt_n       = cnt;
        ft_n        = ft;
        frame_cnt_n = frame_cnt;
        seq_cnt_n   = seq_cnt;
        stop_pend_n = stop_pend;
        end_run     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_n     = ST_RUN;
                    freq_n      = (bus.laser_freq == 32'd0) ? 32'd1 : bus.laser_freq;
                    pbg_n       = bus.pulses_bg;
                    pa_n        = bus.pulses_a;
                    pb_n        = bus.pulses_b;
                    nseq_n      = bus.num_seq;
                    cnt_n       = 32'd0;
                    ft_n        = first_frame(en_in);
                    frame_cnt_n = 16'd0;
                    seq_cnt_n   = 16'd0;
                    stop_pend_n = 1'b0;
                end
            end
            default: begin
                stop_pend_n = stop_pend | bus.stop;
                if (eop) begin
                    cnt_n = 32'd0;
                    // A pending stop wins over any frame or sequence advance on this EOP.
                    if (stop_pend || bus.stop) begin
                        end_run = 1'b1;
                    end else if (frame_cnt_inc == cur_pulses) begin
                        frame_cnt_n = 16'd0;
                        ft_n        = adv_ft;
                        if (adv_wrap) begin
                            seq_cnt_n = seq_inc;
                            if ((nseq_l != 16'd0) && (seq_inc == nseq_l)) begin
                                end_run = 1'b1;
                            end
                        end
                    end else begin
                        frame_cnt_n = frame_cnt_inc;
                    end
                end else begin
                    cnt_n = cnt + 32'd1;
                end

                if (end_run) begin
                    state_n     = ST_IDLE;
                    cnt_n       = 32'd0;
                    ft_n        = FT_BG;
                    frame_cnt_n = 16'd0;
                    seq_cnt_n   = 16'd0;
                    stop_pend_n = 1'b0;
                end
            end
        endcase
    end

    assign trig_lim = (TRIG_LIM < freq_n) ? TRIG_LIM : freq_n;

    logic laser_trig_r, frame_start_r, busy_r, done_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            freq_l        <= 32'd0;
            pbg_l         <= 16'd0;
            pa_l          <= 16'd0;
            pb_l          <= 16'd0;
            nseq_l        <= 16'd0;
            cnt           <= 32'd0;
            ft            <= FT_BG;
            frame_cnt     <= 16'd0;
            seq_cnt       <= 16'd0;
            stop_pend     <= 1'b0;
            laser_trig_r  <= 1'b0;
            frame_start_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state         <= state_n;
            freq_l        <= freq_n;
            pbg_l         <= pbg_n;
            pa_l          <= pa_n;
            pb_l          <= pb_n;
            nseq_l        <= nseq_n;
            cnt           <= cnt_n;
            ft            <= ft_n;
            frame_cnt     <= frame_cnt_n;
            seq_cnt       <= seq_cnt_n;
            stop_pend     <= stop_pend_n;
            laser_trig_r  <= (state_n == ST_RUN) && (cnt_n < trig_lim);
            frame_start_r <= (state_n == ST_RUN) && (cnt_n == 32'd0) && (frame_cnt_n == 16'd0);
            busy_r        <= (state_n == ST_RUN);
            done_r        <= end_run;
        end
    end

    assign bus.laser_cnt_out = cnt;
    assign bus.frame_type    = ft;
    assign bus.laser_trig    = laser_trig_r;
    assign bus.frame_start   = frame_start_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.state_dbg     = state;

endmodule

// File: tb/tb_laser_frame_sequencer.sv
// Self-checking bench for laser_frame_sequencer: per-cycle trace compared against a
// trace expanded from nested sequence/frame/period loops.
module tb_laser_frame_sequencer;
  localparam int TRIG_WIDTH = 16;
  localparam int CAP        = 4000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  laser_frame_sequencer_if bus();

  laser_frame_sequencer #(.TRIG_WIDTH(TRIG_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // {done, busy, frame_start, laser_trig, frame_type[1:0], laser_cnt_out[31:0]}
  logic [37:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [37:0] pack_exp(logic [31:0] cnt, logic [1:0] ft,
                                           logic trig, logic fs, logic busy, logic done);
    return {done, busy, fs, trig, ft, cnt};
  endfunction

  function automatic logic [37:0] observed();
    return {bus.done, bus.busy, bus.frame_start, bus.laser_trig, bus.frame_type, bus.laser_cnt_out};
  endfunction

  localparam logic [37:0] IDLE_WORD = 38'd0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected trace of one run, first entry = cycle after start; ends with done and one idle cycle.
  task automatic build_expected(input logic [31:0] freq, input logic [15:0] bg, input logic [15:0] a,
                                input logic [15:0] b, input logic [15:0] nseq, input int stop_idx);
    int f, lim, n;
    int pc[3];
    bit finished;
    f   = (freq == 32'd0) ? 1 : int'(freq);
    lim = (TRIG_WIDTH < f) ? TRIG_WIDTH : f;
    pc[0] = int'(bg);
    pc[1] = int'(a);
    pc[2] = int'(b);
    exp_q.delete();
    n = 0;
    finished = 1'b0;
    for (int s = 0; !finished; s++) begin
      for (int fr = 0; fr < 3 && !finished; fr++) begin
        for (int p = 0; p < pc[fr] && !finished; p++) begin
          for (int c = 0; c <= f && !finished; c++) begin
            exp_q.push_back(pack_exp(32'(c), 2'(fr), c < lim, (c == 0) && (p == 0), 1'b1, 1'b0));
            if (c == f && stop_idx >= 0 && n >= stop_idx) finished = 1'b1;
            n++;
            if (n > CAP) finished = 1'b1;
          end
        end
      end
      if (nseq != 16'd0 && s + 1 == int'(nseq)) finished = 1'b1;
    end
    exp_q.push_back(pack_exp(32'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(IDLE_WORD);
  endtask

  task automatic run_case(input string tag, input logic [31:0] freq, input logic [15:0] bg,
                          input logic [15:0] a, input logic [15:0] b, input logic [15:0] nseq,
                          input int stop_idx, input int rst_idx, input bit disturb);
    int idx;
    logic [37:0] exp;
    build_expected(freq, bg, a, b, nseq, stop_idx);
    bus.laser_freq = freq;
    bus.pulses_bg  = bg;
    bus.pulses_a   = a;
    bus.pulses_b   = b;
    bus.num_seq    = nseq;
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    idx = 0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check(tag, observed(), exp);
      bus.stop = (idx == stop_idx);
      if (disturb && idx == 2) begin
        bus.laser_freq = 32'($urandom_range(0, 50));
        bus.pulses_bg  = 16'($urandom_range(0, 5));
        bus.pulses_a   = 16'($urandom_range(0, 5));
        bus.pulses_b   = 16'($urandom_range(0, 5));
        bus.num_seq    = 16'($urandom_range(0, 5));
        bus.start      = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (idx == rst_idx) begin
        bus.stop = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check({tag, "_reset"}, observed(), IDLE_WORD);
        check({tag, "_reset_state"}, {37'd0, bus.state_dbg}, 38'd0);
        exp_q.delete();
      end
      step();
      idx++;
    end
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    repeat (2) begin
      check({tag, "_idle_after"}, observed(), IDLE_WORD);
      step();
    end
  endtask

  initial begin
    logic [15:0] rbg, ra, rb;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.laser_freq = 32'd0;
    bus.pulses_bg = 16'd0;
    bus.pulses_a = 16'd0;
    bus.pulses_b = 16'd0;
    bus.num_seq = 16'd0;

    // Clock/reset
    rst_n = 1'b0;
    repeat (3) step();
    check("reset", observed(), IDLE_WORD);
    check("reset_state", {37'd0, bus.state_dbg}, 38'd0);
    rst_n = 1'b1;
    step();
    check("idle", observed(), IDLE_WORD);

    run_case("basic", 32'd9, 16'd2, 16'd3, 16'd1, 16'd1, -1, -1, 1'b0);
    run_case("skip", 32'd4, 16'd1, 16'd0, 16'd1, 16'd2, -1, -1, 1'b0);
    run_case("clamp", 32'd0, 16'd1, 16'd2, 16'd1, 16'd1, -1, -1, 1'b0);

    // Stop while idle must not linger into the next run.
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("stop_idle", observed(), IDLE_WORD);
    run_case("after_idle_stop", 32'd3, 16'd1, 16'd1, 16'd1, 16'd1, -1, -1, 1'b0);

    run_case("stop_mid", 32'd99, 16'd2, 16'd1, 16'd1, 16'd0, 37, -1, 1'b0);
    run_case("disturb", 32'd7, 16'd2, 16'd2, 16'd2, 16'd1, -1, -1, 1'b1);

    // All pulse counts zero: start is ignored.
    bus.laser_freq = 32'd5;
    bus.pulses_bg = 16'd0;
    bus.pulses_a = 16'd0;
    bus.pulses_b = 16'd0;
    bus.num_seq = 16'd1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (3) begin
      check("zero_pulses", observed(), IDLE_WORD);
      step();
    end

    run_case("rst_mid", 32'd9, 16'd2, 16'd3, 16'd1, 16'd1, -1, 25, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rbg = 16'($urandom_range(0, 3));
      ra  = 16'($urandom_range(0, 3));
      rb  = 16'($urandom_range(0, 3));
      if (rbg == 16'd0 && ra == 16'd0 && rb == 16'd0) ra = 16'd1;
      run_case("random", 32'($urandom_range(0, 20)), rbg, ra, rb,
               16'($urandom_range(1, 3)), -1, -1, 1'($urandom_range(0, 1)));
    end

    run_case("random_stop", 32'($urandom_range(2, 12)), 16'd1, 16'd2, 16'd1, 16'd0,
             int'($urandom_range(0, 60)), -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
